// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and types for the instruction-fetch stage.
// Holds reset PC default, NOP encoding, PC step, FSM states, queue entry.
package fetch_pkg;

  localparam logic [31:0] PC_RESET_DEF = 32'h8002_0000;
  localparam logic [31:0] NOP_INSN     = 32'h0000_0000;
  localparam logic [31:0] PC_STEP      = 32'd4;

  typedef enum logic {
    RUN,
    DRAIN
  } state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: small synchronous FIFO, DEPTH a power of 2 (>=2).
// Ports: clock, reset, push, pop, flush, din -> dout, full, empty, count.
module fetch_queue #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // a full queue may take a push when it pops in the same cycle
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push && !flush && !reset) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  overflow_a: assert property (
    @(posedge clock) disable iff (reset)
    !(push && full && !pop)
  );

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: fetch PC, in-order imem requests, instruction queue to decode.
// Ports: clock, reset, imem_req_*, imem_resp_*, stall, redirect(_pc), pc,
// insn, insn_valid; with FETCH_PERF_EN also perf_fetched, perf_bubbles.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_DEF,
  parameter int          QDEPTH   = 2
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc,
  output logic [31:0] insn,
  output logic        insn_valid
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_bubbles
`endif
);

  localparam int          CW = $clog2(QDEPTH) + 1;
  localparam logic [CW:0] QD = (CW+1)'(QDEPTH);

  state_t        state;
  state_t        state_n;
  logic [31:0]   fetch_pc;
  logic [31:0]   fetch_pc_n;
  logic [31:0]   last_pc;
  logic [CW-1:0] discard;
  logic [CW-1:0] discard_n;
  logic [CW-1:0] occ;
  logic [CW-1:0] inflight;
  logic [CW:0]   total;
  logic          fire;
  logic          keep;
  logic          take;
  logic          iq_full;
  logic          iq_empty;
  logic          trk_full;
  logic          trk_empty;
  logic [31:0]   trk_head;
  fetch_entry_t  iq_in;
  fetch_entry_t  iq_head;
  logic          unused_ok;

  assign unused_ok = ^{iq_full, trk_full, trk_empty};

  // queued words plus outstanding requests never exceed queue capacity
  assign total = {1'b0, occ} + {1'b0, inflight};

  assign imem_req_addr  = fetch_pc;
  assign imem_req_valid = !reset && (state == RUN) && !redirect
                          && (total < QD);
  assign fire = imem_req_valid && imem_req_ready;

  assign keep = imem_resp_valid && (discard == '0) && !redirect;
  assign take = insn_valid && !stall && !redirect;

  assign iq_in = '{pc: trk_head, insn: imem_resp_data};

  fetch_queue #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (QDEPTH)
  ) u_iq (
    .clock (clock),
    .reset (reset),
    .push  (keep),
    .pop   (take),
    .flush (redirect),
    .din   (iq_in),
    .dout  (iq_head),
    .full  (iq_full),
    .empty (iq_empty),
    .count (occ)
  );

  // request addresses; every response pops one, kept or dropped
  fetch_queue #(
    .WIDTH (32),
    .DEPTH (QDEPTH)
  ) u_trk (
    .clock (clock),
    .reset (reset),
    .push  (fire),
    .pop   (imem_resp_valid),
    .flush (1'b0),
    .din   (fetch_pc),
    .dout  (trk_head),
    .full  (trk_full),
    .empty (trk_empty),
    .count (inflight)
  );

  assign insn_valid = !iq_empty;
  assign insn       = iq_empty ? NOP_INSN : iq_head.insn;
  assign pc         = iq_empty ? last_pc : iq_head.pc;

  always_comb begin
    state_n    = state;
    discard_n  = discard;
    fetch_pc_n = fetch_pc;
    if (fire) fetch_pc_n = fetch_pc + PC_STEP;
    if (redirect) fetch_pc_n = {redirect_pc[31:2], 2'b00};
    unique case (state)
      RUN: begin
        if (redirect) begin
          // a response landing with the redirect is already stale
          discard_n = inflight - CW'(imem_resp_valid);
          if (discard_n != '0) state_n = DRAIN;
        end
      end
      DRAIN: begin
        if (imem_resp_valid && (discard != '0)) begin
          discard_n = discard - 1'b1;
        end
        if (discard_n == '0) state_n = RUN;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= RUN;
      fetch_pc <= PC_RESET;
      discard  <= '0;
      last_pc  <= PC_RESET;
    end else begin
      state    <= state_n;
      fetch_pc <= fetch_pc_n;
      discard  <= discard_n;
      if (!iq_empty) last_pc <= iq_head.pc;
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_fetched <= '0;
      perf_bubbles <= '0;
    end else begin
      if (keep) perf_fetched <= perf_fetched + 32'd1;
      if (!insn_valid && !stall) perf_bubbles <= perf_bubbles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and random checks of fetch_unit against a
// transaction-level model of the expected fetch/present address streams.
module tb_fetch_unit;

  localparam logic [31:0] PCR = 32'h8002_0000;
  localparam int          QD  = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] pc;
  logic [31:0] insn;
  logic        insn_valid;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_bubbles;
`endif

  always #5 clock = ~clock;

  fetch_unit dut (
    .clock           (clock),
    .reset           (reset),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_pc     (redirect_pc),
    .pc              (pc),
    .insn            (insn),
`ifdef FETCH_PERF_EN
    .perf_fetched    (perf_fetched),
    .perf_bubbles    (perf_bubbles),
`endif
    .insn_valid      (insn_valid)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
    int          ep;
  } req_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] insn;
    int          cyc;
  } pop_t;

  req_t        pend[$];
  pop_t        pops[$];
  logic [31:0] fired[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int epoch = 0;
  int n_pops = 0;
  int lat_lo = 1;
  int lat_hi = 1;
  int rdy_pct = 100;

  logic [31:0] exp_issue = PCR;
  logic [31:0] exp_pop = PCR;
  logic [31:0] prev_pc = PCR;
  logic [31:0] prev_insn = '0;
  logic [31:0] m_fetched = '0;
  logic [31:0] m_bubbles = '0;
  logic        prev_valid = 1'b0;
  logic        prev_stall = 1'b0;
  logic        prev_redir = 1'b0;
  logic        after_redir = 1'b0;

  function automatic logic [31:0] data_of(logic [31:0] a);
    if (a == 32'h8002_0000) return 32'h2008_0005;
    if (a == 32'h8002_0004) return 32'h0109_5020;
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic tick();
    logic [31:0] tgt;
    @(negedge clock);
    imem_req_ready  = (int'($urandom_range(99)) < rdy_pct);
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    if (!reset && pend.size() > 0 && pend[0].due <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = data_of(pend[0].addr);
    end
    #1;
    if (reset) begin
      pend.delete();
      exp_issue   = PCR;
      exp_pop     = PCR;
      m_fetched   = '0;
      m_bubbles   = '0;
      prev_valid  = 1'b0;
      prev_pc     = PCR;
      prev_insn   = '0;
      prev_stall  = 1'b0;
      prev_redir  = 1'b0;
      after_redir = 1'b0;
    end else begin
      if (!insn_valid) begin
        checks++;
        if (insn !== 32'h0) begin
          errors++;
          $display("FAIL nop_insn cyc=%0d got %h want 0", cyc, insn);
        end
        checks++;
        if (pc !== prev_pc) begin
          errors++;
          $display("FAIL pc_hold cyc=%0d got %h want %h", cyc, pc, prev_pc);
        end
      end
      if (insn_valid) begin
        checks++;
        if (pc !== exp_pop || insn !== data_of(exp_pop)) begin
          errors++;
          $display("FAIL head cyc=%0d got %h/%h want %h/%h",
                   cyc, pc, insn, exp_pop, data_of(exp_pop));
        end
      end
      if (imem_req_valid) begin
        checks++;
        if (imem_req_addr !== exp_issue) begin
          errors++;
          $display("FAIL req_addr cyc=%0d got %h want %h",
                   cyc, imem_req_addr, exp_issue);
        end
      end
      if (redirect) begin
        checks++;
        if (imem_req_valid !== 1'b0) begin
          errors++;
          $display("FAIL req_on_redirect cyc=%0d got %b want 0",
                   cyc, imem_req_valid);
        end
      end
      if (after_redir) begin
        checks++;
        if (insn_valid !== 1'b0) begin
          errors++;
          $display("FAIL post_redirect cyc=%0d got %b want 0", cyc, insn_valid);
        end
      end
      if (prev_stall && !prev_redir && prev_valid) begin
        checks++;
        if (insn_valid !== 1'b1 || pc !== prev_pc || insn !== prev_insn) begin
          errors++;
          $display("FAIL stall_hold cyc=%0d got %b %h/%h want 1 %h/%h",
                   cyc, insn_valid, pc, insn, prev_pc, prev_insn);
        end
      end
`ifdef FETCH_PERF_EN
      checks++;
      if (perf_fetched !== m_fetched) begin
        errors++;
        $display("FAIL perf_fetched cyc=%0d got %0d want %0d",
                 cyc, perf_fetched, m_fetched);
      end
      checks++;
      if (perf_bubbles !== m_bubbles) begin
        errors++;
        $display("FAIL perf_bubbles cyc=%0d got %0d want %0d",
                 cyc, perf_bubbles, m_bubbles);
      end
`endif
      if (imem_resp_valid) begin
        if (pend[0].ep == epoch && !redirect) m_fetched++;
        pend.delete(0);
      end
      if (imem_req_valid && imem_req_ready) begin
        pend.push_back('{imem_req_addr,
                         cyc + int'($urandom_range(lat_hi, lat_lo)), epoch});
        fired.push_back(imem_req_addr);
        exp_issue += 32'd4;
      end
      checks++;
      if (pend.size() > QD) begin
        errors++;
        $display("FAIL inflight cyc=%0d got %0d want <=%0d",
                 cyc, pend.size(), QD);
      end
      if (insn_valid && !stall && !redirect) begin
        pops.push_back('{pc, insn, cyc});
        exp_pop += 32'd4;
        n_pops++;
      end
      if (!insn_valid && !stall) m_bubbles++;
      prev_valid  = insn_valid;
      prev_pc     = pc;
      prev_insn   = insn;
      prev_stall  = stall;
      prev_redir  = redirect;
      after_redir = redirect;
      if (redirect) begin
        tgt       = {redirect_pc[31:2], 2'b00};
        exp_issue = tgt;
        exp_pop   = tgt;
        epoch++;
      end
    end
    cyc++;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    stall    = 1'b0;
    redirect = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    fired.delete();
    pops.delete();
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    stall    = 1'b0;
    redirect = 1'b0;
    rdy_pct  = 100;
    lat_lo   = 3;
    lat_hi   = 3;
    tick();
    tick();
    checks++;
    if (imem_req_valid !== 1'b0 || imem_req_addr !== PCR) begin
      errors++;
      $display("FAIL reset_req got %b %h want 0 %h",
               imem_req_valid, imem_req_addr, PCR);
    end
    checks++;
    if (pc !== PCR || insn !== 32'h0 || insn_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_out got %h %h %b want %h 0 0",
               pc, insn, insn_valid, PCR);
    end
    reset = 1'b0;
    fired.delete();
    repeat (3) begin
      tick();
      checks++;
      if (insn_valid !== 1'b0) begin
        errors++;
        $display("FAIL early_valid got %b want 0", insn_valid);
      end
    end
    checks++;
    if (fired.size() < 2) begin
      errors++;
      $display("FAIL first_reqs got %0d reqs want 2", fired.size());
    end else if (fired[0] !== PCR || fired[1] !== PCR + 32'd4) begin
      errors++;
      $display("FAIL first_reqs got %h %h want %h %h",
               fired[0], fired[1], PCR, PCR + 32'd4);
    end
    for (int i = 0; i < 20 && !insn_valid; i++) tick();
    checks++;
    if (insn_valid !== 1'b1) begin
      errors++;
      $display("FAIL first_insn_timeout got %b want 1", insn_valid);
    end
  endtask

  task automatic test_latency1();
    int c0;
    lat_lo = 1;
    lat_hi = 1;
    do_reset();
    c0 = cyc;
    repeat (6) tick();
    checks++;
    if (pops.size() < 2) begin
      errors++;
      $display("FAIL lat1_count got %0d want >=2", pops.size());
    end else begin
      if (pops[0].pc !== PCR || pops[0].insn !== 32'h2008_0005
          || pops[0].cyc != c0 + 2) begin
        errors++;
        $display("FAIL lat1_first got %h/%h@%0d want %h/20080005@%0d",
                 pops[0].pc, pops[0].insn, pops[0].cyc, PCR, c0 + 2);
      end
      checks++;
      if (pops[1].pc !== PCR + 32'd4 || pops[1].insn !== 32'h0109_5020
          || pops[1].cyc != c0 + 3) begin
        errors++;
        $display("FAIL lat1_second got %h/%h@%0d want %h/01095020@%0d",
                 pops[1].pc, pops[1].insn, pops[1].cyc, PCR + 32'd4, c0 + 3);
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] hpc;
    logic [31:0] hinsn;
    lat_lo = 1;
    lat_hi = 1;
    do_reset();
    stall = 1'b1;
    repeat (4) tick();
    hpc   = pc;
    hinsn = insn;
    checks++;
    if (hpc !== PCR || hinsn !== 32'h2008_0005) begin
      errors++;
      $display("FAIL stall_head got %h/%h want %h/20080005", hpc, hinsn, PCR);
    end
    repeat (5) begin
      tick();
      checks++;
      if (imem_req_valid !== 1'b0) begin
        errors++;
        $display("FAIL stall_req got %b want 0", imem_req_valid);
      end
      checks++;
      if (insn_valid !== 1'b1 || pc !== hpc || insn !== hinsn) begin
        errors++;
        $display("FAIL stall_const got %b %h/%h want 1 %h/%h",
                 insn_valid, pc, insn, hpc, hinsn);
      end
    end
    pops.delete();
    stall = 1'b0;
    tick();
    tick();
    checks++;
    if (pops.size() != 2) begin
      errors++;
      $display("FAIL stall_release got %0d pops want 2", pops.size());
    end else if (pops[0].pc !== PCR || pops[1].pc !== PCR + 32'd4
                 || pops[1].cyc != pops[0].cyc + 1) begin
      errors++;
      $display("FAIL stall_release got %h@%0d %h@%0d want %h %h consecutive",
               pops[0].pc, pops[0].cyc, pops[1].pc, pops[1].cyc,
               PCR, PCR + 32'd4);
    end
  endtask

  task automatic test_redirect();
    lat_lo = 3;
    lat_hi = 3;
    do_reset();
    tick();
    tick();
    redirect    = 1'b1;
    redirect_pc = 32'h8002_0103;
    fired.delete();
    pops.delete();
    tick();
    redirect = 1'b0;
    checks++;
    if (imem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_req got %b want 0", imem_req_valid);
    end
    for (int i = 0; i < 30 && pops.size() == 0; i++) tick();
    checks++;
    if (fired.size() == 0 || fired[0] !== 32'h8002_0100) begin
      errors++;
      $display("FAIL redir_addr got %0d reqs first %h want 80020100",
               fired.size(), fired.size() ? fired[0] : 32'h0);
    end
    checks++;
    if (pops.size() == 0 || pops[0].pc !== 32'h8002_0100) begin
      errors++;
      $display("FAIL redir_first got %0d pops first %h want 80020100",
               pops.size(), pops.size() ? pops[0].pc : 32'h0);
    end
  endtask

  task automatic test_redirect_resp_stall();
    lat_lo = 2;
    lat_hi = 2;
    do_reset();
    stall = 1'b1;
    tick();
    tick();
    redirect    = 1'b1;
    redirect_pc = 32'h8002_0200;
    pops.delete();
    tick();
    redirect = 1'b0;
    checks++;
    if (insn_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL rrs_after got valid=%b req=%b want 0 0",
               insn_valid, imem_req_valid);
    end
    tick();
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8002_0200) begin
      errors++;
      $display("FAIL rrs_resume got %b %h want 1 80020200",
               imem_req_valid, imem_req_addr);
    end
    stall = 1'b0;
    for (int i = 0; i < 30 && pops.size() == 0; i++) tick();
    checks++;
    if (pops.size() == 0 || pops[0].pc !== 32'h8002_0200) begin
      errors++;
      $display("FAIL rrs_first got %0d pops first %h want 80020200",
               pops.size(), pops.size() ? pops[0].pc : 32'h0);
    end
  endtask

  task automatic test_wrap();
    lat_lo = 1;
    lat_hi = 1;
    do_reset();
    stall = 1'b1;
    tick();
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFF;
    fired.delete();
    pops.delete();
    tick();
    redirect = 1'b0;
    stall    = 1'b0;
    repeat (10) tick();
    checks++;
    if (fired.size() < 2 || fired[0] !== 32'hFFFF_FFFC
        || fired[1] !== 32'h0) begin
      errors++;
      $display("FAIL wrap_addr got %0d reqs %h %h want fffffffc 00000000",
               fired.size(), fired.size() > 0 ? fired[0] : 32'h0,
               fired.size() > 1 ? fired[1] : 32'h0);
    end
    checks++;
    if (pops.size() < 2 || pops[0].pc !== 32'hFFFF_FFFC
        || pops[1].pc !== 32'h0) begin
      errors++;
      $display("FAIL wrap_pop got %0d pops %h %h want fffffffc 00000000",
               pops.size(), pops.size() > 0 ? pops[0].pc : 32'h0,
               pops.size() > 1 ? pops[1].pc : 32'h0);
    end
  endtask

  task automatic test_random();
    lat_lo  = 1;
    lat_hi  = 4;
    rdy_pct = 70;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      stall       = ($urandom_range(99) < 30);
      redirect    = ($urandom_range(99) < 5);
      redirect_pc = ($urandom_range(9) == 0) ? 32'hFFFF_FFF0 | $urandom_range(15)
                                             : $urandom;
      reset       = ($urandom_range(999) < 4);
      tick();
    end
    reset    = 1'b0;
    stall    = 1'b0;
    redirect = 1'b0;
  endtask

  task automatic test_drain();
    int start;
    rdy_pct = 100;
    stall    = 1'b0;
    redirect = 1'b0;
    start = n_pops;
    for (int i = 0; i < 200 && n_pops < start + 10; i++) tick();
    checks++;
    if (n_pops < start + 10) begin
      errors++;
      $display("FAIL progress got %0d pops want %0d", n_pops - start, 10);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_latency1();
    test_stall();
    test_redirect();
    test_redirect_resp_stall();
    test_wrap();
    test_random();
    test_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
